// File: rtl/display_timing_gen_if.sv
// Panel-side signal bundle for display_timing_gen: the run request in, all timing outputs back.
interface display_timing_gen_if;
    logic       enable;
    logic [9:0] disp_x;
    logic [9:0] disp_y;
    logic       DEN;
    logic       HSYNC;
    logic       VSYNC;
    logic       DISP_CLK;
    logic       DISP_EN;
    logic       frame_start;

    modport master (
        input  enable,
        output disp_x, disp_y, DEN, HSYNC, VSYNC, DISP_CLK, DISP_EN, frame_start
    );

    modport slave (
        output enable,
        input  disp_x, disp_y, DEN, HSYNC, VSYNC, DISP_CLK, DISP_EN, frame_start
    );
endinterface

// File: rtl/display_timing_gen.sv
// Parallel-RGB panel timing generator: pixel-clock divider, h/v scan counters,
// registered sync/DE decode and a frame-delayed panel enable.
module display_timing_gen #(
    parameter int CLK_DIV         = 4,
    parameter int H_SYNC          = 41,
    parameter int H_BP            = 2,
    parameter int H_ACTIVE        = 480,
    parameter int H_FP            = 2,
    parameter int V_SYNC          = 10,
    parameter int V_BP            = 2,
    parameter int V_ACTIVE        = 272,
    parameter int V_FP            = 2,
    parameter int EN_DELAY_FRAMES = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    display_timing_gen_if.master   tif
);
    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_MAX  = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
    // Totals above 1023 do not fit the 10-bit counters and are not supported.
    localparam logic [9:0] H_LAST  = 10'(H_SYNC + H_BP + H_ACTIVE + H_FP - 1);
    localparam logic [9:0] V_LAST  = 10'(V_SYNC + V_BP + V_ACTIVE + V_FP - 1);
    localparam logic [9:0] H_SYNCE = 10'(H_SYNC);
    localparam logic [9:0] V_SYNCE = 10'(V_SYNC);
    localparam logic [9:0] H_ACT0  = 10'(H_SYNC + H_BP);
    localparam logic [9:0] H_ACT1  = 10'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [9:0] V_ACT0  = 10'(V_SYNC + V_BP);
    localparam logic [9:0] V_ACT1  = 10'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [3:0] EN_DLY  = 4'(EN_DELAY_FRAMES);

    typedef enum logic {ST_IDLE, ST_RUN} state_e;

    state_e          state_q, state_d;
    logic [DW-1:0]   div_q, div_d;
    logic [9:0]      h_q, h_d, v_q, v_d;
    logic [3:0]      frm_q, frm_d;
    logic            en_q, en_d;
    logic            fs_q, fs_d;
    logic            dclk_q, dclk_d;
    logic            den_q, den_d;
    logic            hs_q, hs_d;
    logic            vs_q, vs_d;
    logic [9:0]      x_q, x_d, y_q, y_d;
    logic            pixel_tick, h_act, v_act;

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        h_d        = h_q;
        v_d        = v_q;
        frm_d      = frm_q;
        en_d       = en_q;
        fs_d       = 1'b0;
        pixel_tick = 1'b0;

        if (!tif.enable) begin
            state_d = ST_IDLE;
            div_d   = '0;
            h_d     = '0;
            v_d     = '0;
            frm_d   = '0;
            en_d    = 1'b0;
        end else begin
            case (state_q)
                // First enabled edge lands on the frame origin, as if a frame just wrapped.
                ST_IDLE: begin
                    state_d = ST_RUN;
                    div_d   = '0;
                    h_d     = '0;
                    v_d     = '0;
                    fs_d    = 1'b1;
                end
                default: begin
                    pixel_tick = (div_q == DIV_MAX);
                    div_d      = pixel_tick ? '0 : div_q + 1'b1;
                    if (pixel_tick) begin
                        if (h_q == H_LAST) begin
                            h_d = '0;
                            if (v_q == V_LAST) begin
                                v_d  = '0;
                                fs_d = 1'b1;
                            end else begin
                                v_d = v_q + 10'd1;
                            end
                        end else begin
                            h_d = h_q + 10'd1;
                        end
                    end
                end
            endcase

            if (fs_d && !en_q) begin
                if (frm_q == EN_DLY) en_d  = 1'b1;
                else                 frm_d = frm_q + 4'd1;
            end
        end

        // Decode from next-state counters so outputs line up with the counter registers.
        h_act  = (h_d >= H_ACT0) && (h_d < H_ACT1);
        v_act  = (v_d >= V_ACT0) && (v_d < V_ACT1);
        den_d  = tif.enable && h_act && v_act;
        hs_d   = !(tif.enable && (h_d < H_SYNCE));
        vs_d   = !(tif.enable && (v_d < V_SYNCE));
        dclk_d = tif.enable && (div_d >= DIV_HALF);
        x_d    = den_d ? h_d - H_ACT0 : '0;
        y_d    = den_d ? v_d - V_ACT0 : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            h_q     <= '0;
            v_q     <= '0;
            frm_q   <= '0;
            en_q    <= 1'b0;
            fs_q    <= 1'b0;
            dclk_q  <= 1'b0;
            den_q   <= 1'b0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            h_q     <= h_d;
            v_q     <= v_d;
            frm_q   <= frm_d;
            en_q    <= en_d;
            fs_q    <= fs_d;
            dclk_q  <= dclk_d;
            den_q   <= den_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    assign tif.disp_x      = x_q;
    assign tif.disp_y      = y_q;
    assign tif.DEN         = den_q;
    assign tif.HSYNC       = hs_q;
    assign tif.VSYNC       = vs_q;
    assign tif.DISP_CLK    = dclk_q;
    assign tif.DISP_EN     = en_q;
    assign tif.frame_start = fs_q;
endmodule

// File: tb/tb_display_timing_gen.sv
// Directed bench for display_timing_gen on a shrunken raster: 8-pixel lines,
// 6-line frames, 2 clk per pixel, so one frame is 96 clk.
module tb_display_timing_gen;
    // H: sync 2, bp 1, active 4 (h 3..6), fp 1. V: sync 1, bp 1, active 3 (v 2..4), fp 1.
    // After edge k of a run: div = k%2, h = (k/2)%8, v = (k/16)%6.
    logic clk;
    logic reset_n;
    int   n_vec;
    int   n_err;

    display_timing_gen_if tif();

    display_timing_gen #(
        .CLK_DIV(2), .H_SYNC(2), .H_BP(1), .H_ACTIVE(4), .H_FP(1),
        .V_SYNC(1), .V_BP(1), .V_ACTIVE(3), .V_FP(1), .EN_DELAY_FRAMES(2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .tif     (tif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_den"},  32'(tif.DEN), 0);
        chk({tag, "_hs"},   32'(tif.HSYNC), 1);
        chk({tag, "_vs"},   32'(tif.VSYNC), 1);
        chk({tag, "_dclk"}, 32'(tif.DISP_CLK), 0);
        chk({tag, "_fs"},   32'(tif.frame_start), 0);
        chk({tag, "_en"},   32'(tif.DISP_EN), 0);
        chk({tag, "_x"},    32'(tif.disp_x), 0);
        chk({tag, "_y"},    32'(tif.disp_y), 0);
    endtask

    initial begin
        int den_cnt, hs_cnt, vs_cnt, fs_cnt, dclk_cnt, viol;
        logic p_den, p_hs, p_vs, p_dclk;
        n_vec = 0; n_err = 0;
        den_cnt = 0; hs_cnt = 0; vs_cnt = 0; fs_cnt = 0; dclk_cnt = 0; viol = 0;
        p_den = 0; p_hs = 1; p_vs = 1; p_dclk = 0;
        reset_n = 1'b0;
        tif.enable = 1'b0;
        repeat (3) step();
        chk_idle("rst");
        #2 reset_n = 1'b1;
        repeat (3) step();
        chk_idle("idle");

        // First run: raster shape, per-frame totals and the DISP_EN delay.
        tif.enable = 1'b1;
        for (int k = 0; k <= 230; k++) begin
            step();
            if (k < 96) begin
                den_cnt  += int'(tif.DEN);
                hs_cnt   += int'(!tif.HSYNC);
                vs_cnt   += int'(!tif.VSYNC);
                fs_cnt   += int'(tif.frame_start);
                dclk_cnt += int'(tif.DISP_CLK);
            end
            if (k >= 1 && (tif.DEN != p_den || tif.HSYNC != p_hs || tif.VSYNC != p_vs)
                && !(p_dclk && !tif.DISP_CLK))
                viol++;
            p_den = tif.DEN; p_hs = tif.HSYNC; p_vs = tif.VSYNC; p_dclk = tif.DISP_CLK;
            case (k)
                0: begin
                    chk("k0_fs", 32'(tif.frame_start), 1);
                    chk("k0_hs", 32'(tif.HSYNC), 0);
                    chk("k0_vs", 32'(tif.VSYNC), 0);
                    chk("k0_dclk", 32'(tif.DISP_CLK), 0);
                    chk("k0_en", 32'(tif.DISP_EN), 0);
                end
                1: begin
                    chk("k1_fs", 32'(tif.frame_start), 0);
                    chk("k1_dclk", 32'(tif.DISP_CLK), 1);
                end
                3:  chk("k3_hs_low", 32'(tif.HSYNC), 0);
                4:  chk("k4_hs_high", 32'(tif.HSYNC), 1);
                6:  chk("k6_den_vblank", 32'(tif.DEN), 0);
                15: chk("k15_vs_low", 32'(tif.VSYNC), 0);
                16: chk("k16_vs_high", 32'(tif.VSYNC), 1);
                36: chk("k36_den_bp", 32'(tif.DEN), 0);
                38: begin
                    chk("first_den", 32'(tif.DEN), 1);
                    chk("first_x", 32'(tif.disp_x), 0);
                    chk("first_y", 32'(tif.disp_y), 0);
                    chk("first_dclk", 32'(tif.DISP_CLK), 0);
                end
                44: chk("k44_x", 32'(tif.disp_x), 3);
                46: begin
                    chk("k46_den_fp", 32'(tif.DEN), 0);
                    chk("k46_x", 32'(tif.disp_x), 0);
                end
                58: chk("k58_y", 32'(tif.disp_y), 1);
                76: begin
                    chk("last_den", 32'(tif.DEN), 1);
                    chk("last_x", 32'(tif.disp_x), 3);
                    chk("last_y", 32'(tif.disp_y), 2);
                end
                78: chk("k78_den", 32'(tif.DEN), 0);
                86: chk("k86_den_vfp", 32'(tif.DEN), 0);
                95: begin
                    chk("k95_fs", 32'(tif.frame_start), 0);
                    chk("k95_hs", 32'(tif.HSYNC), 1);
                    chk("k95_vs", 32'(tif.VSYNC), 1);
                    chk("den_per_frame", 32'(den_cnt), 24);
                    chk("hs_low_per_frame", 32'(hs_cnt), 24);
                    chk("vs_low_per_frame", 32'(vs_cnt), 16);
                    chk("fs_per_frame", 32'(fs_cnt), 1);
                    chk("dclk_high_per_frame", 32'(dclk_cnt), 48);
                end
                96: begin
                    chk("wrap_fs", 32'(tif.frame_start), 1);
                    chk("wrap_hs", 32'(tif.HSYNC), 0);
                    chk("wrap_vs", 32'(tif.VSYNC), 0);
                    chk("wrap_en", 32'(tif.DISP_EN), 0);
                end
                97:  chk("k97_fs", 32'(tif.frame_start), 0);
                191: chk("en_before", 32'(tif.DISP_EN), 0);
                192: begin
                    chk("en_rise", 32'(tif.DISP_EN), 1);
                    chk("en_rise_fs", 32'(tif.frame_start), 1);
                end
                230: begin
                    chk("pre_drop_den", 32'(tif.DEN), 1);
                    chk("pre_drop_en", 32'(tif.DISP_EN), 1);
                end
                default: ;
            endcase
        end
        chk("sync_on_dclk_fall", 32'(viol), 0);

        // Enable dropped mid-active: idle one edge later, then a full restart.
        tif.enable = 1'b0;
        step();
        chk_idle("drop");
        step();
        fs_cnt = 0;
        tif.enable = 1'b1;
        for (int k = 0; k <= 192; k++) begin
            step();
            fs_cnt += int'(tif.frame_start);
            case (k)
                0: begin
                    chk("re_fs", 32'(tif.frame_start), 1);
                    chk("re_en", 32'(tif.DISP_EN), 0);
                end
                96:  chk("re_fs2", 32'(tif.frame_start), 1);
                191: chk("re_en_before", 32'(tif.DISP_EN), 0);
                192: begin
                    chk("re_en_rise", 32'(tif.DISP_EN), 1);
                    chk("re_fs_count", 32'(fs_cnt), 3);
                end
                default: ;
            endcase
        end

        // Asynchronous reset pulse mid-active, between clock edges.
        repeat (39) step();
        chk("pre_rst_den", 32'(tif.DEN), 1);
        chk("pre_rst_dclk", 32'(tif.DISP_CLK), 1);
        #3 reset_n = 1'b0;
        #1;
        chk_idle("async_rst");
        #2 reset_n = 1'b1;
        for (int k = 0; k <= 96; k++) begin
            step();
            case (k)
                0: begin
                    chk("post_rst_fs", 32'(tif.frame_start), 1);
                    chk("post_rst_hs", 32'(tif.HSYNC), 0);
                    chk("post_rst_vs", 32'(tif.VSYNC), 0);
                end
                1:  chk("post_rst_fs_off", 32'(tif.frame_start), 0);
                38: chk("post_rst_den", 32'(tif.DEN), 1);
                95: chk("post_rst_fs95", 32'(tif.frame_start), 0);
                96: begin
                    chk("post_rst_fs96", 32'(tif.frame_start), 1);
                    chk("post_rst_en", 32'(tif.DISP_EN), 0);
                end
                default: ;
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/display_timing_gen.md
DISPLAY_TIMING_GEN -- requirements
Module: display_timing_gen

Interface
REQ-001 Parameter CLK_DIV, default 4: clk cycles per pixel; even, >= 2.
REQ-002 Parameters H_SYNC=41, H_BP=2, H_ACTIVE=480, H_FP=2: horizontal segment lengths in pixels; H_TOTAL = sum = 525.
REQ-003 Parameters V_SYNC=10, V_BP=2, V_ACTIVE=272, V_FP=2: vertical segment lengths in lines; V_TOTAL = sum = 286.
REQ-004 Parameter EN_DELAY_FRAMES, default 2: complete frames after enable before DISP_EN rises; range 0..15.
REQ-005 clk  input  1  system clock; all logic is clocked on its rising edge.
REQ-006 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-007 enable  input  1  run request; low holds the timing generator idle.
REQ-008 disp_x  output  10  active-area column 0..479; 0 outside the active area.
REQ-009 disp_y  output  10  active-area row 0..271; 0 outside the active area.
REQ-010 DEN  output  1  data enable; high only inside the active area.
REQ-011 HSYNC  output  1  horizontal sync, active-low.
REQ-012 VSYNC  output  1  vertical sync, active-low.
REQ-013 DISP_CLK  output  1  pixel clock to the panel.
REQ-014 DISP_EN  output  1  panel enable.
REQ-015 frame_start  output  1  one-clk pulse at the start of each frame.

Function
REQ-016 The divider counter div_cnt SHALL count 0..CLK_DIV-1 and wrap; pixel_tick SHALL be asserted when div_cnt == CLK_DIV-1.
REQ-017 DISP_CLK SHALL be a registered output: low while div_cnt < CLK_DIV/2, high otherwise (50% duty cycle); the panel samples on the DISP_CLK rising edge.
REQ-018 h_cnt SHALL advance only on pixel_tick, over the range 0..H_TOTAL-1, wrapping to 0; v_cnt SHALL advance when h_cnt wraps, over the range 0..V_TOTAL-1, wrapping to 0.
REQ-019 Segment order per line: sync, back porch, active, front porch. HSYNC low iff h_cnt < H_SYNC; h active iff H_SYNC+H_BP <= h_cnt < H_SYNC+H_BP+H_ACTIVE (h_cnt 43..522 at defaults).
REQ-020 The vertical decode SHALL use the same order: VSYNC low iff v_cnt < V_SYNC; v active iff v_cnt is in 12..283 at defaults.
REQ-021 DEN = h active AND v active; disp_x = h_cnt - 43 and disp_y = v_cnt - 12 when DEN is high, else both 0.
REQ-022 DEN, HSYNC, VSYNC, disp_x and disp_y SHALL be registered and decoded from the next-state counter values, so they change on the same clk edge as the counters; they therefore change only coincident with a DISP_CLK falling edge.
REQ-023 frame_start SHALL be high for exactly one clk, on the edge where h_cnt and v_cnt both become 0.
REQ-024 Subtraction widths: all arithmetic SHALL be 10-bit unsigned; a parameter set with H_TOTAL > 1023 or V_TOTAL > 1023 is illegal.
REQ-025 enable low: div_cnt, h_cnt and v_cnt held at 0; DISP_CLK low; HSYNC, VSYNC high; DEN 0; disp_x, disp_y 0; frame_start 0; DISP_EN 0; frame-delay counter cleared.
REQ-026 enable rising: counting SHALL start on the next clk with div_cnt = 0; the first frame_start pulse SHALL occur on the first clk with enable high.
REQ-027 DISP_EN SHALL rise on the frame_start edge after EN_DELAY_FRAMES complete frames have been counted; with EN_DELAY_FRAMES = 0 it rises on the first frame_start.
REQ-028 DISP_EN SHALL remain high until enable falls or reset; it SHALL drop on the same clk that enable is sampled low.
REQ-029 enable falling mid-frame SHALL abort the frame immediately (REQ-025 state); no partial-line completion.

Reset
REQ-030 reset_n low SHALL asynchronously force all counters to 0, DISP_CLK 0, HSYNC 1, VSYNC 1, DEN 0, disp_x 0, disp_y 0, frame_start 0, DISP_EN 0.
REQ-031 After reset_n deasserts, the block SHALL behave as REQ-026 if enable is high.
REQ-032 Reset asserted mid-frame SHALL leave no residual state; the next run SHALL start from frame_start.

Verification
REQ-033 Defaults, enable held high: DISP_CLK period 4 clk; HSYNC low 164 clk per 2100-clk line; VSYNC low 21000 clk; frame_start period 600600 clk.
REQ-034 Active-area scan: 130560 DEN-high pixels per frame; first pixel (0,0) at h_cnt 43, v_cnt 12; last pixel (479,271); disp_x, disp_y both 0 whenever DEN is low.
REQ-035 DISP_EN delay: DISP_EN rises exactly 1201200 clk after the first frame_start (EN_DELAY_FRAMES = 2); with EN_DELAY_FRAMES = 0 it rises coincident with the first frame_start.
REQ-036 enable dropped at v_cnt 100, h_cnt 200: all outputs reach REQ-025 values one edge later; on re-enable, frame_start fires on the first clk and DISP_EN waits a full 2 frames again.
REQ-037 reset_n pulsed low mid-active-line asynchronously (no clk edge): outputs clear immediately; on release, timing matches REQ-033 from a fresh frame_start.
REQ-038 Wrap corner: at h_cnt 524, v_cnt 285 pixel_tick, both counters wrap to 0 together, frame_start pulses, HSYNC and VSYNC both fall on the same edge.
